rr_grant_encoder_8: RTL and testbench

//  Round-robin arbiter over 8 request lines. Emits the winning index as a 3-bit

---
 rtl/rr_grant_encoder_8_pkg.sv | 16 +
 rtl/rr_grant_encoder_8_pick.sv | 27 ++
 rtl/rr_grant_encoder_8.sv | 86 ++++++++
 tb/tb_rr_grant_encoder_8.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_encoder_8_pkg.sv
// Shared definitions for the 8-way round-robin grant encoder: state encoding,
// requester/index sizing and the pointer reset value.
package rr_grant_encoder_8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    // Pointer resets to the last index so the first search begins at requester 0.
    localparam logic [IDX_W-1:0] LAST_PTR_RST = 3'd7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_grant_encoder_8_pick.sv
// Rotating-priority search: returns the first set request strictly after
// i_last_ptr, wrapping 7->0, with i_last_ptr itself examined last.
module rr_pick_8
    import rr_grant_encoder_8_pkg::*;
(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Walk from the farthest offset to the nearest so the nearest set bit wins.
    always_comb begin
        logic [IDX_W-1:0] w_cand;
        w_cand = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = i_last_ptr + IDX_W'(k);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder_8.sv
// Round-robin arbiter over 8 requesters with grant hold, abort and timeout
// release; outputs feed a 3x8 decoder (in = grant_idx, en = grant_en).
module rr_grant_encoder_8
    import rr_grant_encoder_8_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_en,
    output logic             timeout,
    output logic             busy
);

    state_t           r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_last_ptr;
    logic [IDX_W-1:0] r_grant_idx;
    logic             r_grant_en;
    logic             r_timeout;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_abort;
    logic             w_hold_last;
    logic             w_release;

    rr_pick_8 u_pick (
        .i_req      (req),
        .i_last_ptr (r_last_ptr),
        .o_idx      (w_pick_idx),
        .o_any      (w_pick_any)
    );

    // Release causes in priority order: done, requester abort, hold expiry.
    assign w_abort     = ~req[r_grant_idx];
    assign w_hold_last = (r_hold_cnt == CNT_W'(HOLD_MAX - 1));
    assign w_release   = done | w_abort | w_hold_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_cnt  <= '0;
            r_last_ptr  <= LAST_PTR_RST;
            r_grant_idx <= '0;
            r_grant_en  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant_idx <= w_pick_idx;
                        r_grant_en  <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_state     <= ST_GRANT;
                    end else begin
                        r_grant_en  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_grant_en <= 1'b0;
                        r_last_ptr <= r_grant_idx;
                        r_hold_cnt <= '0;
                        r_timeout  <= ~done & ~w_abort;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_idx = r_grant_idx;
    assign grant_en  = r_grant_en;
    assign timeout   = r_timeout;
    assign busy      = (r_state == ST_GRANT);

endmodule

// File: tb/tb_rr_grant_encoder_8.sv
// Directed bench for rr_grant_encoder_8: a cycle model checked every falling
// edge, plus literal expectations for the grant sequences and boundary cases.
module tb_rr_grant_encoder_8;

    localparam int HOLD_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] grant_idx;
    logic       grant_en;
    logic       timeout;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_grant_encoder_8 #(.HOLD_MAX(HOLD_MAX), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant_idx (grant_idx),
        .grant_en  (grant_en),
        .timeout   (timeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "granted" flag, owner, cycles held so far, last owner.
    bit       m_en;
    int       m_idx;
    bit       m_to;
    int       m_ptr;
    int       m_age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_en = 0; m_idx = 0; m_to = 0; m_ptr = 7; m_age = 0;
        end else begin
            m_to = 0;
            if (!m_en) begin
                if (req != 8'h00) begin
                    for (int off = 8; off >= 1; off--) begin
                        if (req[(m_ptr + off) % 8]) m_idx = (m_ptr + off) % 8;
                    end
                    m_en  = 1;
                    m_age = 1;
                end
            end else if (done || !req[m_idx] || m_age == HOLD_MAX) begin
                m_to  = !done && req[m_idx];
                m_en  = 0;
                m_ptr = m_idx;
                m_age = 0;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_grant_en", grant_en, m_en);
        chk("cyc_grant_idx", grant_idx, m_idx);
        chk("cyc_timeout", timeout, m_to);
        chk("cyc_busy", busy, m_en);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    // Returns at a point where grant_en is high; gap = cycles spent waiting.
    task automatic wait_grant(input string name, output int gap);
        gap = 0;
        while (!grant_en && gap < 40) begin
            step(1);
            gap++;
        end
        if (!grant_en) chk({name, "_wait_expired"}, 0, 1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    logic [7:0] dec_out;
    int         gap;
    int         held;
    int         exp2 [4] = '{0, 2, 0, 2};

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        step(2);
        rst = 1'b0;

        // 1: idle with no requests; done in IDLE must be ignored
        step(2);
        pulse_done();
        step(2);
        chk("t1_en", grant_en, 0);
        chk("t1_idx", grant_idx, 0);
        chk("t1_timeout", timeout, 0);

        // 2: two requesters alternate, 1-cycle gap between grants
        req = 8'h05;
        for (int g = 0; g < 4; g++) begin
            wait_grant("t2", gap);
            if (g > 0) chk("t2_gap", gap, 1);
            chk("t2_idx", grant_idx, exp2[g]);
            pulse_done();
            chk("t2_en_low", grant_en, 0);
        end

        // 3: all requesting, done one cycle into each grant
        do_reset();
        req = 8'hFF;
        for (int g = 0; g < 9; g++) begin
            wait_grant("t3", gap);
            chk("t3_idx", grant_idx, g % 8);
            step(1);
            chk("t3_idx_hold", grant_idx, g % 8);
            pulse_done();
        end

        // 4: no done -> forced release after 16 grant cycles, then re-grant
        do_reset();
        req = 8'h10;
        wait_grant("t4", gap);
        held = 0;
        while (grant_en && held < 40) begin
            chk("t4_idx", grant_idx, 4);
            held++;
            step(1);
        end
        chk("t4_held", held, 16);
        chk("t4_timeout", timeout, 1);
        wait_grant("t4b", gap);
        chk("t4_regrant_gap", gap, 1);
        chk("t4_regrant_idx", grant_idx, 4);
        chk("t4_timeout_clr", timeout, 0);

        // 4b: done on the timeout cycle wins, no timeout pulse
        do_reset();
        req = 8'h10;
        wait_grant("t4c", gap);
        step(15);
        chk("t4c_still_en", grant_en, 1);
        pulse_done();
        chk("t4c_en", grant_en, 0);
        chk("t4c_timeout", timeout, 0);

        // 5: requester abort, then pointer resumes after 3
        do_reset();
        req = 8'h08;
        wait_grant("t5", gap);
        chk("t5_idx", grant_idx, 3);
        step(1);
        req = 8'h00;
        step(1);
        chk("t5_en", grant_en, 0);
        chk("t5_timeout", timeout, 0);
        req = 8'h09;
        wait_grant("t5b", gap);
        chk("t5_next_idx", grant_idx, 0);
        req = 8'h00;
        pulse_done();

        // 6: async reset mid-grant, then search restarts at 0
        do_reset();
        req = 8'h40;
        wait_grant("t6", gap);
        chk("t6_idx", grant_idx, 6);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_en", grant_en, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_idx", grant_idx, 0);
        step(1);
        rst = 1'b0;
        req = 8'hC0;
        wait_grant("t6b", gap);
        chk("t6_first_idx", grant_idx, 6);
        dec_out = grant_en ? (8'b1 << grant_idx) : 8'h00;
        chk("t6_decoder", dec_out, 8'h40);
        pulse_done();
        wait_grant("t6c", gap);
        chk("t6_next_idx", grant_idx, 7);
        req = 8'h00;
        pulse_done();
        step(2);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
